seq_priority_encoder: RTL and testbench



---
 rtl/seq_priority_encoder.sv | 124 ++++++++++++
 tb/tb_seq_priority_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_priority_encoder.sv
// Sequential N-to-W encoder: accepts a request vector, then emits the index of
// each set bit (lowest first) as one handshaked beat per bit, with last/zero flags.
module seq_priority_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero,
    output logic [W:0]   out_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic           zflag_q, zflag_d;
    logic [W:0]     cnt_q, cnt_d;

    logic [W-1:0]   idx_s;
    logic           single_s;
    logic           last_s;

    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        logic         found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && !found) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic exactly_one(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - {{(N-1){1'b0}}, 1'b1})) == '0);
    endfunction

    assign idx_s    = lowest_idx(pend_q);
    assign single_s = exactly_one(pend_q);
    // A zero vector still produces one dummy beat, which must be flagged last.
    assign last_s   = single_s | zflag_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == BUSY);
    assign out_idx   = idx_s;
    assign out_last  = (state_q == BUSY) & last_s;
    assign out_zero  = zflag_q;
    assign out_cnt   = cnt_q;

    // Next-state: capture a vector in IDLE, retire one pending bit per beat in BUSY.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zflag_d = zflag_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in_vec;
                    cnt_d   = popcount(in_vec);
                    zflag_d = (in_vec == '0);
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pend_d = pend_q & ~({{(N-1){1'b0}}, 1'b1} << idx_s);
                    if (last_s) begin
                        state_d = IDLE;
                        zflag_d = 1'b0;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset; a reset drops any pending beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zflag_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zflag_q <= zflag_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Self-checking bench for seq_priority_encoder: directed scenarios plus randomized
// vectors with random backpressure, checked against a bit-list reference model.
module tb_seq_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_zero;
    logic [3:0] out_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_cnt;

    always #5 clk = ~clk;

    seq_priority_encoder #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_cnt   (out_cnt)
    );

    // Reference: list of set-bit positions in ascending order; a zero vector yields one index-0 beat.
    function automatic void model(input logic [7:0] v);
        exp_q.delete();
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                exp_q.push_back(i);
                exp_cnt++;
            end
        end
        if (exp_cnt == 0) exp_q.push_back(0);
    endfunction

    // Observed tuple: {out_valid, out_idx, out_last, out_zero, out_cnt, in_ready}
    function automatic logic [10:0] obs();
        return {out_valid, out_idx, out_last, out_zero, out_cnt, in_ready};
    endfunction

    function automatic logic [10:0] beat_exp(input int b);
        logic last;
        logic zero;
        last = (b == exp_q.size() - 1);
        zero = (exp_cnt == 0);
        return {1'b1, 3'(exp_q[b]), last, zero, 4'(exp_cnt), 1'b0};
    endfunction

    function automatic logic [10:0] idle_exp(input int cnt);
        return {1'b0, 3'b000, 1'b0, 1'b0, 4'(cnt), 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = 8'h00;
        repeat (2) step();
        checks++;
        if (obs() !== idle_exp(0)) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs(), idle_exp(0));
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs() !== idle_exp(0)) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs(), idle_exp(0));
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        model(8'hA4);
        accept(8'hA4);
        for (int b = 0; b < exp_q.size(); b++) begin
            checks++;
            if (obs() !== beat_exp(b)) begin
                errors++;
                $display("FAIL basic_beat%0d: got %b expected %b", b, obs(), beat_exp(b));
            end
            step();
        end
        checks++;
        if (obs() !== idle_exp(3)) begin
            errors++;
            $display("FAIL basic_idle: got %b expected %b", obs(), idle_exp(3));
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        model(8'hA4);
        accept(8'hA4);
        for (int b = 0; b < exp_q.size(); b++) begin
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (obs() !== beat_exp(b)) begin
                    errors++;
                    $display("FAIL stall_hold%0d_%0d: got %b expected %b", b, s, obs(), beat_exp(b));
                end
                step();
            end
            checks++;
            if (obs() !== beat_exp(b)) begin
                errors++;
                $display("FAIL stall_beat%0d: got %b expected %b", b, obs(), beat_exp(b));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        checks++;
        if (obs() !== idle_exp(3)) begin
            errors++;
            $display("FAIL stall_idle: got %b expected %b", obs(), idle_exp(3));
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        model(8'h00);
        accept(8'h00);
        checks++;
        if (obs() !== beat_exp(0)) begin
            errors++;
            $display("FAIL zero_beat: got %b expected %b", obs(), beat_exp(0));
        end
        step();
        checks++;
        if (obs() !== idle_exp(0)) begin
            errors++;
            $display("FAIL zero_idle: got %b expected %b", obs(), idle_exp(0));
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        model(8'hFF);
        accept(8'hFF);
        for (int b = 0; b < exp_q.size(); b++) begin
            checks++;
            if (obs() !== beat_exp(b)) begin
                errors++;
                $display("FAIL ones_beat%0d: got %b expected %b", b, obs(), beat_exp(b));
            end
            step();
        end
        checks++;
        if (obs() !== idle_exp(8)) begin
            errors++;
            $display("FAIL ones_idle: got %b expected %b", obs(), idle_exp(8));
        end
        model(8'h80);
        accept(8'h80);
        checks++;
        if (obs() !== beat_exp(0)) begin
            errors++;
            $display("FAIL b2b_beat: got %b expected %b", obs(), beat_exp(0));
        end
        step();
        checks++;
        if (obs() !== idle_exp(1)) begin
            errors++;
            $display("FAIL b2b_idle: got %b expected %b", obs(), idle_exp(1));
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        model(8'h0F);
        accept(8'h0F);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (obs() !== beat_exp(b)) begin
                errors++;
                $display("FAIL arst_beat%0d: got %b expected %b", b, obs(), beat_exp(b));
            end
            if (b < 2) step();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== idle_exp(0)) begin
            errors++;
            $display("FAIL arst_immediate: got %b expected %b", obs(), idle_exp(0));
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (obs() !== idle_exp(0)) begin
                errors++;
                $display("FAIL arst_nobeat%0d: got %b expected %b", c, obs(), idle_exp(0));
            end
        end
        model(8'h10);
        accept(8'h10);
        checks++;
        if (obs() !== beat_exp(0)) begin
            errors++;
            $display("FAIL arst_next_beat: got %b expected %b", obs(), beat_exp(0));
        end
        step();
        checks++;
        if (obs() !== idle_exp(1)) begin
            errors++;
            $display("FAIL arst_next_idle: got %b expected %b", obs(), idle_exp(1));
        end
    endtask

    task automatic test_ignore_inputs();
        out_ready = 1'b1;
        model(8'h22);
        accept(8'h22);
        for (int b = 0; b < exp_q.size(); b++) begin
            checks++;
            if (obs() !== beat_exp(b)) begin
                errors++;
                $display("FAIL ignore_beat%0d: got %b expected %b", b, obs(), beat_exp(b));
            end
            in_valid = 1'($urandom_range(0, 1));
            in_vec   = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (obs() !== idle_exp(2)) begin
            errors++;
            $display("FAIL ignore_idle: got %b expected %b", obs(), idle_exp(2));
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic       r;
        int         b;
        int         cyc;
        for (int n = 0; n < 25; n++) begin
            v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(v);
            out_ready = 1'($urandom_range(0, 1));
            accept(v);
            b   = 0;
            cyc = 0;
            while (b < exp_q.size() && cyc < 100) begin
                checks++;
                if (obs() !== beat_exp(b)) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d vec=%h: got %b expected %b", n, b, v, obs(), beat_exp(b));
                end
                r = 1'($urandom_range(0, 1));
                out_ready = r;
                step();
                cyc++;
                if (r) b++;
            end
            checks++;
            if (b < exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_timeout: got %0d beats expected %0d", n, b, exp_q.size());
            end
            checks++;
            if (obs() !== idle_exp(exp_cnt)) begin
                errors++;
                $display("FAIL rand%0d_idle vec=%h: got %b expected %b", n, v, obs(), idle_exp(exp_cnt));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_back_to_back();
        test_async_reset();
        test_ignore_inputs();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
